key_sched_engine: RTL and testbench
===================================

# key_sched_engine

Sequential, parametrised round-key schedule engine for the 16-bit AES datapath; serves both the encryption and decryption modules. On a start pulse it expands one input key into NR round keys, one round per clock, into an internal key buffer. Both cipher cores then read the buffered keys through a registered read port, so the key path no longer needs one combinational key generator per round.

## Interface
- KEY_W, 16: key width in bits; multiple of 16, 16..64.
- NR, 10: number of generated round keys; 1..10.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request expansion; sampled only in IDLE.
- mode  in  1  0 = forward (S-box), 1 = inverse (inverse S-box); captured with start.
- key_in  in  KEY_W  round-0 key; captured with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when last key is written.
- keys_valid  out  1  buffer holds a complete schedule for the captured key.
- rk_rd  in  1  read strobe.
- rk_addr  in  4  slot index 0..NR.
- rk_data  out  KEY_W  registered read data.

## Operation
- Buffer: NR+1 slots of KEY_W. Slot 0 = captured key. Slot r+1 = F(slot r, r).
- Forward: F(k,i) = k ^ SubWord(k) ^ (RC[i] << (KEY_W-8)).
- Inverse: F(k,i) = k ^ InvSubWord(k) ^ (RC[NR-1-i] << (KEY_W-8)).
- RC[0..9] = 01,02,04,08,10,20,40,80,1b,36. RC occupies the top byte only. All XORs are KEY_W wide; there is no carry.
- SubWord/InvSubWord: bytewise AES S-box / inverse S-box built from the existing subByte/invSubByte slices, one slice per 16 bits.
- FSM:
  - IDLE --start--> RUN: capture key_in into slot 0 and latch mode; round=0; keys_valid<=0.
  - RUN: each cycle write F(slot round, round) into slot round+1.
    - round < NR-1: round++.
    - round == NR-1: go to DONE.
  - DONE: done=1, keys_valid<=1; next state IDLE.
- start outside IDLE is ignored; no queueing.
- Read port:
  - rk_rd sampled at a rising edge updates rk_data at that edge.
  - rk_data = slot[rk_addr] if keys_valid and rk_addr<=NR; otherwise 0.
  - Without rk_rd, rk_data holds its value.
  - Reads during RUN return 0, because keys_valid is low.

## Timing
- Reset values: state IDLE, round 0, busy 0, done 0, keys_valid 0, rk_data 0.
- Buffer contents are not reset. They are masked by keys_valid.
- Start accepted at edge E0 (slot 0 written). Slot r written at edge Er, r=1..NR.
- DONE is entered at edge E_NR. done and keys_valid are high after E_NR, and busy drops after E_NR+1.
- Total latency: start to done = NR+1 edges. A new start is accepted at E_NR+2 or later.
- rst during RUN/DONE: FSM returns to IDLE and keys_valid=0. No done pulse is issued; the schedule must be restarted.
- rst and start in the same cycle: rst wins.
- rk_rd in the same cycle as start: the read uses pre-start keys_valid, then keys_valid clears.

## Configuration
- KEYSCHED_INV_EN defined:
  - mode input honoured.
  - invSubByte slices instantiated; inverse schedule available.
- Undefined:
  - mode ignored; forward only.
  - no invSubByte logic synthesised.
  - Port list unchanged.

## Test plan
- Forward, KEY_W=16, NR=10, key_in=0x0000, mode=0 -> slot1 = 0x6263; done exactly 11 edges after start; slot0 reads 0x0000.
- Inverse (KEYSCHED_INV_EN), key_in=0x0000, mode=1 -> slot1 = 0x0000^0x5252^0x3600 = 0x6452; slot10 uses RC 0x01.
- start pulsed during RUN with key_in=0xFFFF -> ignored; schedule and done timing match the original key.
- rst asserted at E5 -> busy=0, keys_valid=0, no done pulse; rk_addr=3 read returns 0x0000; restart completes normally.
- rk_addr=11 (>NR) with keys_valid=1 -> rk_data=0; rk_addr=NR -> final key one edge after rk_rd.
- NR=1, KEY_W=32, key_in=0x00000000 forward -> slot1 = 0x62636363; done 2 edges after start.

Source files
------------

// File: rtl/key_sched_engine_if.sv
// Bundle between the round-key schedule engine and its users (cipher cores / control).
// Handshake: start is a request taken only while busy is low; rk_rd at an edge yields rk_data after that edge.
interface key_sched_engine_if #(
  parameter int KEY_W = 16
);
  logic             start;
  logic             mode;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             done;
  logic             keys_valid;
  logic             rk_rd;
  logic [3:0]       rk_addr;
  logic [KEY_W-1:0] rk_data;

  modport master (
    output start, mode, key_in, rk_rd, rk_addr,
    input  busy, done, keys_valid, rk_data
  );

  modport slave (
    input  start, mode, key_in, rk_rd, rk_addr,
    output busy, done, keys_valid, rk_data
  );
endinterface

// File: rtl/key_sched_engine.sv
// Sequential round-key expansion into a key buffer, one round per clock, with a registered read port.
// Define KEYSCHED_INV_EN to honour mode and build the inverse (InvSubWord) schedule.
module key_sched_engine #(
  parameter int KEY_W = 16,
  parameter int NR    = 10
) (
  input  logic              clk,
  input  logic              rst,
  key_sched_engine_if.slave ks,
  output logic [1:0]        dbg_state
);
  localparam int AW = $clog2(NR + 1);
  localparam int NB = KEY_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

`ifdef KEYSCHED_INV_EN
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
    return INV_SBOX[8*(255 - int'(x)) +: 8];
  endfunction
`endif

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t           state, state_nx;
  logic [3:0]       round;
  logic             kv_q;
  logic [KEY_W-1:0] cur_key;
  logic [KEY_W-1:0] sub_word;
  logic [KEY_W-1:0] next_key;
  logic [3:0]       rc_idx;
  logic [KEY_W-1:0] rd_q;
  logic [KEY_W-1:0] kbuf [0:NR];
  logic             start_acc;
  logic             last_round;

  assign start_acc  = (state == S_IDLE) && ks.start;
  assign last_round = (round == 4'(NR - 1));

`ifdef KEYSCHED_INV_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (start_acc) inv_q <= ks.mode;
  end

  always_comb begin
    sub_word = '0;
    for (int b = 0; b < NB; b++) begin
      sub_word[8*b +: 8] = inv_q ? inv_sub_byte(cur_key[8*b +: 8]) : sub_byte(cur_key[8*b +: 8]);
    end
  end

  // Inverse schedule walks the round constants from the top down.
  assign rc_idx = inv_q ? (4'(NR - 1) - round) : round;
`else
  logic unused_mode;
  assign unused_mode = ks.mode;

  always_comb begin
    sub_word = '0;
    for (int b = 0; b < NB; b++) begin
      sub_word[8*b +: 8] = sub_byte(cur_key[8*b +: 8]);
    end
  end

  assign rc_idx = round;
`endif

  assign next_key = cur_key ^ sub_word ^ {rcon(rc_idx), {(KEY_W-8){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ks.start) state_nx = S_RUN;
      S_RUN:   if (last_round) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round <= 4'd0;
      kv_q  <= 1'b0;
    end else if (start_acc) begin
      round <= 4'd0;
      kv_q  <= 1'b0;
    end else if (state == S_RUN) begin
      if (last_round) kv_q  <= 1'b1;
      else            round <= round + 4'd1;
    end
  end

  // Buffer contents are deliberately unreset; kv_q masks stale slots at the read port.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      kbuf[0] <= ks.key_in;
      cur_key <= ks.key_in;
    end else if (state == S_RUN) begin
      kbuf[AW'(round + 4'd1)] <= next_key;
      cur_key                 <= next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (ks.rk_rd) begin
      rd_q <= (kv_q && (ks.rk_addr <= 4'(NR))) ? kbuf[AW'(ks.rk_addr)] : '0;
    end
  end

  assign ks.busy       = (state != S_IDLE);
  assign ks.done       = (state == S_DONE);
  assign ks.keys_valid = kv_q;
  assign ks.rk_data    = rd_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_key_sched_engine.sv
// Bench for key_sched_engine: a 16-bit/NR=10 instance and a 32-bit/NR=1 instance,
// directed schedules with hand-derived round keys checked through a read-data scoreboard.
module tb_key_sched_engine;
  logic clk;
  logic rst;
  logic [1:0] dbg_a, dbg_b;

  key_sched_engine_if #(.KEY_W(16)) ka ();
  key_sched_engine_if #(.KEY_W(32)) kb ();

  key_sched_engine #(.KEY_W(16), .NR(10)) u_a (.clk(clk), .rst(rst), .ks(ka), .dbg_state(dbg_a));
  key_sched_engine #(.KEY_W(32), .NR(1))  u_b (.clk(clk), .rst(rst), .ks(kb), .dbg_state(dbg_b));

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  logic [15:0] exp_a_q[$];
  string       nm_a_q[$];
  logic [31:0] exp_b_q[$];
  string       nm_b_q[$];

  // Forward schedule for key 0x0000, slots 0..10.
  logic [15:0] fwd0 [11] = '{16'h0000, 16'h6263, 16'hca98, 16'hbade, 16'h46c3, 16'h0ced,
                             16'hd2b8, 16'h27d4, 16'h6b9c, 16'h0f42, 16'h4f6e};
`ifdef KEYSCHED_INV_EN
  localparam logic [15:0] MODE1_SLOT1 = 16'h6452;
`else
  localparam logic [15:0] MODE1_SLOT1 = 16'h6263;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read-data monitors: a read strobed at an edge is checked after that edge.
  bit rd_a_seen, rd_b_seen;
  always begin
    @(posedge clk);
    rd_a_seen = ka.rk_rd;
    rd_b_seen = kb.rk_rd;
    @(negedge clk);
    if (ka.done) done_cnt_a++;
    if (kb.done) done_cnt_b++;
    if (rd_a_seen) begin
      if (exp_a_q.size() == 0) check("sb_a_underflow", 64'd1, 64'd0);
      else check(nm_a_q.pop_front(), 64'(ka.rk_data), 64'(exp_a_q.pop_front()));
    end
    if (rd_b_seen) begin
      if (exp_b_q.size() == 0) check("sb_b_underflow", 64'd1, 64'd0);
      else check(nm_b_q.pop_front(), 64'(kb.rk_data), 64'(exp_b_q.pop_front()));
    end
  end

  task automatic read_a(input logic [3:0] a, input logic [15:0] e, input string nm);
    @(negedge clk);
    ka.rk_rd = 1'b1;
    ka.rk_addr = a;
    exp_a_q.push_back(e);
    nm_a_q.push_back(nm);
    @(negedge clk);
    ka.rk_rd = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    kb.rk_rd = 1'b1;
    kb.rk_addr = a;
    exp_b_q.push_back(e);
    nm_b_q.push_back(nm);
    @(negedge clk);
    kb.rk_rd = 1'b0;
  endtask

  // c counts edges from the accepting edge (c=1 is E0); pulse_at/rst_at name the edge E<k>.
  task automatic run_a(input logic [15:0] key, input logic m, input int pulse_at, input int rst_at,
                       input bit rd_at_start, input logic [15:0] rd_exp,
                       output int lat, output bit saw_done);
    lat = 0;
    saw_done = 1'b0;
    @(negedge clk);
    ka.start = 1'b1;
    ka.key_in = key;
    ka.mode = m;
    if (rd_at_start) begin
      ka.rk_rd = 1'b1;
      ka.rk_addr = 4'd10;
      exp_a_q.push_back(rd_exp);
      nm_a_q.push_back("rd_with_start");
    end
    for (int c = 1; c <= 20 && !saw_done; c++) begin
      @(posedge clk);
      @(negedge clk);
      ka.start = 1'b0;
      ka.rk_rd = 1'b0;
      ka.key_in = 16'h0000;
      rst = 1'b0;
      if (ka.done) begin
        saw_done = 1'b1;
        lat = c;
      end else begin
        if (c == pulse_at) begin
          ka.start = 1'b1;
          ka.key_in = 16'hffff;
          ka.mode = 1'b1;
        end
        if (c == 2) begin
          ka.rk_rd = 1'b1;
          ka.rk_addr = 4'd0;
          exp_a_q.push_back(16'h0000);
          nm_a_q.push_back("rd_in_run");
        end
        if (c == rst_at) rst = 1'b1;
      end
    end
  endtask

  int lat;
  bit sd;

  initial begin
    rst = 1'b1;
    ka.start = 1'b0; ka.mode = 1'b0; ka.key_in = '0; ka.rk_rd = 1'b0; ka.rk_addr = '0;
    kb.start = 1'b0; kb.mode = 1'b0; kb.key_in = '0; kb.rk_rd = 1'b0; kb.rk_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 64'(ka.busy), 64'd0);
    check("rst_done", 64'(ka.done), 64'd0);
    check("rst_kv", 64'(ka.keys_valid), 64'd0);
    check("rst_rk_data", 64'(ka.rk_data), 64'd0);
    check("rst_state", 64'(dbg_a), 64'd0);
    check("rst_b_rk_data", 64'(kb.rk_data), 64'd0);
    read_a(4'd0, 16'h0000, "rd_before_valid");

    // Forward schedule, key 0.
    run_a(16'h0000, 1'b0, 0, 0, 1'b0, 16'h0000, lat, sd);
    check("fwd_done_seen", 64'(sd), 64'd1);
    check("fwd_latency", 64'(lat), 64'd11);
    check("kv_at_done", 64'(ka.keys_valid), 64'd1);
    check("busy_at_done", 64'(ka.busy), 64'd1);
    @(negedge clk);
    check("busy_after_done", 64'(ka.busy), 64'd0);
    check("done_one_cycle", 64'(ka.done), 64'd0);
    check("idle_after_done", 64'(dbg_a), 64'd0);
    for (int i = 0; i <= 10; i++) read_a(4'(i), fwd0[i], $sformatf("fwd_slot%0d", i));
    repeat (3) @(negedge clk);
    check("rd_hold", 64'(ka.rk_data), 64'(fwd0[10]));
    read_a(4'd11, 16'h0000, "addr_gt_nr");
    read_a(4'd15, 16'h0000, "addr_15");
    read_a(4'd10, fwd0[10], "addr_nr");

    // Start pulsed during RUN is ignored; read issued with start sees the old schedule.
    run_a(16'h0000, 1'b0, 4, 0, 1'b1, fwd0[10], lat, sd);
    check("glitch_done_seen", 64'(sd), 64'd1);
    check("glitch_latency", 64'(lat), 64'd11);
    read_a(4'd1, fwd0[1], "glitch_slot1");
    read_a(4'd10, fwd0[10], "glitch_slot10");

    run_a(16'h0000, 1'b1, 0, 0, 1'b0, 16'h0000, lat, sd);
    check("mode1_latency", 64'(lat), 64'd11);
    read_a(4'd1, MODE1_SLOT1, "mode1_slot1");

    run_a(16'hffff, 1'b0, 0, 0, 1'b0, 16'h0000, lat, sd);
    check("ffff_latency", 64'(lat), 64'd11);
    read_a(4'd0, 16'hffff, "ffff_slot0");
    read_a(4'd1, 16'he8e9, "ffff_slot1");
    read_a(4'd2, 16'h71f7, "ffff_slot2");

    // Reset at E5 aborts the schedule without a done pulse.
    run_a(16'h0000, 1'b0, 0, 5, 1'b0, 16'h0000, lat, sd);
    check("rst_run_no_done", 64'(sd), 64'd0);
    check("rst_run_busy", 64'(ka.busy), 64'd0);
    check("rst_run_kv", 64'(ka.keys_valid), 64'd0);
    check("rst_run_state", 64'(dbg_a), 64'd0);
    read_a(4'd3, 16'h0000, "rd_after_rst");
    run_a(16'h0000, 1'b0, 0, 0, 1'b0, 16'h0000, lat, sd);
    check("restart_latency", 64'(lat), 64'd11);
    read_a(4'd3, fwd0[3], "restart_slot3");
    read_a(4'd10, fwd0[10], "restart_slot10");

    // 32-bit key, single round.
    @(negedge clk);
    kb.start = 1'b1;
    kb.key_in = 32'h0000_0000;
    sd = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10 && !sd; c++) begin
      @(posedge clk);
      @(negedge clk);
      kb.start = 1'b0;
      if (kb.done) begin
        sd = 1'b1;
        lat = c;
      end
    end
    check("b_latency", 64'(lat), 64'd2);
    check("b_kv_at_done", 64'(kb.keys_valid), 64'd1);
    read_b(4'd0, 32'h0000_0000, "b_slot0");
    read_b(4'd1, 32'h6263_6363, "b_slot1");
    read_b(4'd2, 32'h0000_0000, "b_addr_gt_nr");

    repeat (3) @(negedge clk);
    check("done_pulses_a", 64'(done_cnt_a), 64'd5);
    check("done_pulses_b", 64'(done_cnt_b), 64'd1);
    check("sb_a_drained", 64'(exp_a_q.size()), 64'd0);
    check("sb_b_drained", 64'(exp_b_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
